// File: rtl/fu_alu_wb_buffer_if.sv
// Handshake bundle between fu_alu, its writeback buffer, the register-file
// write port and the operand-select forwarding lookup.
interface fu_alu_wb_buffer_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [RW-1:0] in_rd;

    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_rd;

    logic [RW-1:0] fwd_rs;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    modport master (
        output in_valid, in_data, in_rd, wb_ready, fwd_rs,
        input  in_ready, wb_valid, wb_data, wb_rd, fwd_hit, fwd_data
    );

    modport slave (
        input  in_valid, in_data, in_rd, wb_ready, fwd_rs,
        output in_ready, wb_valid, wb_data, wb_rd, fwd_hit, fwd_data
    );
endinterface

// File: rtl/fu_alu_wb_buffer.sv
// In-order writeback FIFO behind fu_alu: absorbs write-port stalls and
// offers a combinational forwarding lookup over the queued results.
module fu_alu_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int RW    = 5
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    fu_alu_wb_buffer_if.slave        bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [DW-1:0] data_mem [DEPTH];
    logic [RW-1:0] rd_mem   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   occ;

    logic do_store;
    logic do_deq;
    logic fwd_hit_c;
    logic [DW-1:0] fwd_data_c;

    assign bus.in_ready = (occ != FULL);
    assign bus.wb_valid = (occ != '0);

    // Writes to x0 complete the handshake but are never queued.
    assign do_store = bus.in_valid && bus.in_ready && !flush && (bus.in_rd != '0);
    assign do_deq   = bus.wb_valid && bus.wb_ready && !flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (do_store) tail <= tail + 1'b1;
            if (do_deq)   head <= head + 1'b1;
            occ <= occ + (PW+1)'(do_store) - (PW+1)'(do_deq);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_store) begin
            data_mem[tail] <= bus.in_data;
            rd_mem[tail]   <= bus.in_rd;
        end
    end

    assign bus.wb_data = bus.wb_valid ? data_mem[head] : '0;
    assign bus.wb_rd   = bus.wb_valid ? rd_mem[head]   : '0;
    assign count       = occ;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW+1)'(i) < occ) && (bus.fwd_rs != '0) && (rd_mem[idx] == bus.fwd_rs)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = data_mem[idx];
            end
        end
    end

    assign bus.fwd_hit  = fwd_hit_c;
    assign bus.fwd_data = fwd_data_c;
endmodule

// File: tb/tb_fu_alu_wb_buffer.sv
// Directed and randomized checks of fu_alu_wb_buffer against a queue-based
// reference model of the writeback FIFO.
module tb_fu_alu_wb_buffer;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int RW    = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] rd;
    } ent_t;

    logic CLK;
    logic nRST;
    logic flush;
    logic [$clog2(DEPTH):0] count;

    fu_alu_wb_buffer_if #(.DW(DW), .RW(RW)) bus ();

    fu_alu_wb_buffer #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .flush (flush),
        .count (count),
        .bus   (bus.slave)
    );

    ent_t q[$];
    int n_chk;
    int n_fail;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic          e_hit;
        logic [DW-1:0] e_fwd;
        e_hit = 1'b0;
        e_fwd = '0;
        if (bus.fwd_rs != '0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].rd == bus.fwd_rs) begin
                    e_hit = 1'b1;
                    e_fwd = q[i].data;
                    break;
                end
            end
        end
        chk({tag, ".count"},    32'(count),        32'(q.size()));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(q.size() != DEPTH));
        chk({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'(q.size() != 0));
        chk({tag, ".wb_data"},  bus.wb_data,       (q.size() != 0) ? q[0].data : 32'd0);
        chk({tag, ".wb_rd"},    32'(bus.wb_rd),    (q.size() != 0) ? 32'(q[0].rd) : 32'd0);
        chk({tag, ".fwd_hit"},  32'(bus.fwd_hit),  32'(e_hit));
        chk({tag, ".fwd_data"}, bus.fwd_data,      e_fwd);
    endtask

    // One clock: drive inputs, check outputs before the edge, then advance the model.
    task automatic step(input string tag, input logic v, input logic [DW-1:0] d, input logic [RW-1:0] rd,
                        input logic rdy, input logic fl, input logic [RW-1:0] rs);
        logic acc;
        logic deq;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_rd    = rd;
        bus.wb_ready = rdy;
        bus.fwd_rs   = rs;
        flush        = fl;
        #1;
        check_all(tag);
        acc = v && (q.size() < DEPTH);
        deq = (q.size() != 0) && rdy;
        @(posedge CLK);
        if (fl) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            if (acc && rd != '0) q.push_back('{data: d, rd: rd});
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_rd    = '0;
        bus.wb_ready = 1'b0;
        bus.fwd_rs   = '0;
        flush        = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle_inputs();
        nRST = 1'b1;
        #2 nRST = 1'b0;
        #1;
        check_all("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1 nRST = 1'b1;

        // Single pass with a stalled write port
        step("sp_enq", 1, 32'd5, 5'd3, 0, 0, 5'd0);
        chk("sp.latency_valid", 32'(bus.wb_valid), 32'd1);
        chk("sp.latency_data", bus.wb_data, 32'd5);
        for (int k = 0; k < 3; k++) begin
            step("sp_hold", 0, 32'd0, 5'd0, 0, 0, 5'd0);
            chk("sp.hold_data", bus.wb_data, 32'd5);
            chk("sp.hold_rd", 32'(bus.wb_rd), 32'd3);
        end
        step("sp_deq", 0, 32'd0, 5'd0, 1, 0, 5'd0);
        chk("sp.drained", 32'(bus.wb_valid), 32'd0);

        // Fill, reject when full, then wrap the pointers
        for (int k = 1; k <= 4; k++)
            step("fill", 1, 32'h10 + 32'(k - 1), 5'(k), 0, 0, 5'd0);
        chk("fill.count", 32'(count), 32'd4);
        chk("fill.in_ready", 32'(bus.in_ready), 32'd0);
        step("full_reject", 1, 32'h99, 5'd12, 0, 0, 5'd0);
        chk("full.count", 32'(count), 32'd4);
        for (int k = 1; k <= 2; k++) begin
            chk("order", 32'(bus.wb_rd), 32'(k));
            step("drain2", 0, 32'd0, 5'd0, 1, 0, 5'd0);
        end
        step("wrap5", 1, 32'h14, 5'd5, 0, 0, 5'd0);
        step("wrap6", 1, 32'h15, 5'd6, 0, 0, 5'd0);
        for (int k = 3; k <= 6; k++) begin
            chk("order", 32'(bus.wb_rd), 32'(k));
            chk("order_data", bus.wb_data, 32'h10 + 32'(k - 1));
            step("drain_all", 0, 32'd0, 5'd0, 1, 0, 5'd0);
        end

        // x0 destination and simultaneous enqueue/dequeue
        step("x0", 1, 32'hDEAD, 5'd0, 0, 0, 5'd0);
        chk("x0.count", 32'(count), 32'd0);
        step("sim_a", 1, 32'h80, 5'd8, 0, 0, 5'd0);
        step("sim_b", 1, 32'h90, 5'd9, 0, 0, 5'd0);
        step("sim_both", 1, 32'hA0, 5'd10, 1, 0, 5'd0);
        chk("sim.count", 32'(count), 32'd2);
        chk("sim.head", 32'(bus.wb_rd), 32'd9);
        step("sim_d1", 0, 32'd0, 5'd0, 1, 0, 5'd0);
        step("sim_d2", 0, 32'd0, 5'd0, 1, 0, 5'd0);

        // Forwarding picks the youngest match and ignores x0 and the input port
        step("fwd_in_port", 1, 32'hA, 5'd7, 0, 0, 5'd7);
        step("fwd_b", 1, 32'hB, 5'd7, 0, 0, 5'd7);
        bus.in_valid = 1'b0;
        bus.fwd_rs   = 5'd7;
        #1;
        chk("fwd7.hit", 32'(bus.fwd_hit), 32'd1);
        chk("fwd7.data", bus.fwd_data, 32'hB);
        bus.fwd_rs = 5'd0;
        #1;
        chk("fwd0.hit", 32'(bus.fwd_hit), 32'd0);
        chk("fwd0.data", bus.fwd_data, 32'd0);
        bus.fwd_rs = 5'd9;
        #1;
        chk("fwd9.hit", 32'(bus.fwd_hit), 32'd0);
        step("fwd_d1", 0, 32'd0, 5'd0, 1, 0, 5'd7);
        step("fwd_d2", 0, 32'd0, 5'd0, 1, 0, 5'd7);
        chk("fwd_drained.hit", 32'(bus.fwd_hit), 32'd0);

        // Flush wins over a same-cycle enqueue and dequeue
        for (int k = 0; k < 3; k++)
            step("fl_fill", 1, 32'h100 + 32'(k), 5'(k + 1), 0, 0, 5'd0);
        step("flush", 1, 32'h555, 5'd11, 1, 1, 5'd11);
        chk("flush.count", 32'(count), 32'd0);
        chk("flush.wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("flush.fwd", 32'(bus.fwd_hit), 32'd0);
        step("post_flush", 1, 32'h66, 5'd6, 0, 0, 5'd0);
        chk("post_flush.rd", 32'(bus.wb_rd), 32'd6);

        // Asynchronous reset in the middle of a drain
        step("rst_f1", 1, 32'h201, 5'd1, 1, 0, 5'd0);
        step("rst_f2", 1, 32'h202, 5'd2, 0, 0, 5'd0);
        step("rst_f3", 1, 32'h203, 5'd3, 0, 0, 5'd0);
        chk("rst.pre_count", 32'(count), 32'd3);
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        #2 nRST = 1'b0;
        q.delete();
        #1;
        chk("rst_mid.count", 32'(count), 32'd0);
        chk("rst_mid.wb_valid", 32'(bus.wb_valid), 32'd0);
        check_all("rst_mid");
        idle_inputs();
        @(posedge CLK);
        #1 nRST = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step("rand", 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 15)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0),
                 5'($urandom_range(0, 15)));
        end
        idle_inputs();
        #1;
        check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
